// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared encodings for the PC-update controller and anything else that
// needs to speak its language (e.g. a future branch predictor).
//   cond_e  : 3-bit branch-condition select carried on cond_sel
//   state_e : controller FSM states
//   cond_is_static() : true for conditions that never depend on ALU flags
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'b000,
    COND_EQ     = 3'b001,
    COND_NE     = 3'b010,
    COND_GT     = 3'b011,
    COND_LT     = 3'b100,
    COND_GE     = 3'b101,
    COND_LE     = 3'b110,
    COND_ALWAYS = 3'b111
  } cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // "never" and "always" resolve without looking at zero/gt, so they can
  // be decided even when the flags are not valid yet.
  function automatic logic cond_is_static(input logic [2:0] sel);
    return (sel == COND_NEVER) || (sel == COND_ALWAYS);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval
// Purely combinational decode of the 8-way branch condition from the ALU
// zero and signed greater-than flags.
// Ports:
//   cond_sel  in  3  condition select (see pc_ctrl_pkg::cond_e)
//   zero      in  1  ALU result was zero
//   gt        in  1  ALU signed greater-than
//   take      out 1  branch condition holds
module branch_cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [2:0] cond_sel,
  input  logic       zero,
  input  logic       gt,
  output logic       take
);

  // LT is "neither greater nor equal"; LE is simply "not greater".
  always_comb begin
    take = 1'b0;
    case (cond_sel)
      COND_NEVER:  take = 1'b0;
      COND_EQ:     take = zero;
      COND_NE:     take = ~zero;
      COND_GT:     take = gt;
      COND_LT:     take = ~gt & ~zero;
      COND_GE:     take = gt | zero;
      COND_LE:     take = ~gt;
      COND_ALWAYS: take = 1'b1;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl
// PC-update controller for the multicycle CPU. Owns the PC and EPC
// registers, resolves conditional branches from the ALU flags, and parks
// in a WAIT state (with timeout) when the flags arrive late.
// Optional feature: define PC_BRANCH_STATS_EN to build the saturating
// taken / not-taken branch counters; otherwise both outputs are tied to 0.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   pc_write              unconditional PC load from next_pc
//   pc_write_cond         conditional PC load from next_pc
//   cond_sel [2:0]        branch condition select
//   next_pc  [WIDTH]      load target
//   zero, gt, flags_valid ALU flags and their valid qualifier
//   except                exception request (EPC <= PC, PC <= EXC_VEC)
//   pc, epc  [WIDTH]      current PC, PC saved at last exception
//   busy                  controller waiting for flags; control FSM holds
//   taken                 1-cycle pulse: PC loaded by a branch
//   cond_err              1-cycle pulse: wait for flags timed out
//   taken_cnt, ntaken_cnt [CNT_W] branch statistics
module pc_branch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC  = 'hFC,
  parameter int               TIMEOUT  = 4,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic [2:0]       cond_sel,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             zero,
  input  logic             gt,
  input  logic             flags_valid,
  input  logic             except,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             busy,
  output logic             taken,
  output logic             cond_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_INIT = TMO_W'(TIMEOUT - 1);

  state_e           state;
  logic [WIDTH-1:0] tgt_q;
  logic [2:0]       cond_q;
  logic [TMO_W-1:0] tmo;

  logic [2:0]       eval_sel;
  logic [WIDTH-1:0] branch_target;
  logic             take;
  logic             resolve;
  logic             launch_wait;

  // While waiting, the condition and target captured at request time are
  // used; the live cond_sel/next_pc may already belong to something else.
  always_comb begin
    eval_sel      = cond_sel;
    branch_target = next_pc;
    if (state == ST_WAIT) begin
      eval_sel      = cond_q;
      branch_target = tgt_q;
    end
  end

  branch_cond_eval u_eval (
    .cond_sel (eval_sel),
    .zero     (zero),
    .gt       (gt),
    .take     (take)
  );

  // Decide whether a branch is resolved this cycle or must wait for flags.
  // except and pc_write both pre-empt any branch activity. In WAIT a new
  // pc_write_cond is ignored: only the pending branch can resolve.
  always_comb begin
    resolve     = 1'b0;
    launch_wait = 1'b0;
    if (!except && !pc_write) begin
      if (state == ST_IDLE) begin
        if (pc_write_cond) begin
          if (flags_valid || cond_is_static(cond_sel)) begin
            resolve = 1'b1;
          end else begin
            launch_wait = 1'b1;
          end
        end
      end else if (flags_valid) begin
        resolve = 1'b1;
      end
    end
  end

  // Controller FSM plus PC/EPC registers. taken/cond_err are pulses that
  // default low every cycle. The timeout counter is loaded with TIMEOUT-1
  // so busy stays high for exactly TIMEOUT cycles before cond_err fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      epc      <= '0;
      busy     <= 1'b0;
      taken    <= 1'b0;
      cond_err <= 1'b0;
      tgt_q    <= '0;
      cond_q   <= COND_NEVER;
      tmo      <= '0;
    end else begin
      taken    <= 1'b0;
      cond_err <= 1'b0;
      if (except) begin
        epc   <= pc;
        pc    <= EXC_VEC;
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (pc_write) begin
        pc    <= next_pc;
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (resolve) begin
        if (take) begin
          pc    <= branch_target;
          taken <= 1'b1;
        end
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (launch_wait) begin
        tgt_q  <= next_pc;
        cond_q <= cond_sel;
        tmo    <= TMO_INIT;
        state  <= ST_WAIT;
        busy   <= 1'b1;
      end else if (state == ST_WAIT) begin
        if (tmo == '0) begin
          cond_err <= 1'b1;
          state    <= ST_IDLE;
          busy     <= 1'b0;
        end else begin
          tmo <= tmo - TMO_W'(1);
        end
      end
    end
  end

`ifdef PC_BRANCH_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Only resolved branches are counted; timeouts and branches dropped by
  // except/pc_write never reach resolve. Counters stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (resolve) begin
      if (take) begin
        if (taken_cnt != CNT_MAX) taken_cnt <= taken_cnt + CNT_W'(1);
      end else begin
        if (ntaken_cnt != CNT_MAX) ntaken_cnt <= ntaken_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign taken_cnt  = '0;
  assign ntaken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb_pc_branch_ctrl
// Self-checking bench for pc_branch_ctrl. Each stimulus cycle pushes its
// expected outputs onto a scoreboard queue; after the clock edge the entry
// is popped and compared against the DUT.
module tb_pc_branch_ctrl;

  localparam int          WIDTH   = 32;
  localparam int          CNT_W   = 2;
  localparam int          TIMEOUT = 4;
  localparam logic [31:0] EXC_VEC = 32'hFC;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;

`ifdef PC_BRANCH_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pc_write;
  logic              pc_write_cond;
  logic [2:0]        cond_sel;
  logic [WIDTH-1:0]  next_pc;
  logic              zero;
  logic              gt;
  logic              flags_valid;
  logic              except;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  epc;
  logic              busy;
  logic              taken;
  logic              cond_err;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  ntaken_cnt;

  pc_branch_ctrl #(
    .WIDTH    (WIDTH),
    .RESET_PC (32'h0),
    .EXC_VEC  (EXC_VEC),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .cond_sel      (cond_sel),
    .next_pc       (next_pc),
    .zero          (zero),
    .gt            (gt),
    .flags_valid   (flags_valid),
    .except        (except),
    .pc            (pc),
    .epc           (epc),
    .busy          (busy),
    .taken         (taken),
    .cond_err      (cond_err),
    .taken_cnt     (taken_cnt),
    .ntaken_cnt    (ntaken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        busy;
    logic        taken;
    logic        cond_err;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_epc;
  int          m_taken;
  int          m_ntaken;

  // Truth table indexed [cond_sel][pattern], pattern 0:(z,g)=00 1:01 2:10
  logic [2:0] truth [8];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pw, input logic pwc,
                               input logic [2:0] cs, input logic [31:0] npc,
                               input logic z, input logic g, input logic fv,
                               input logic ex, input logic [31:0] e_pc,
                               input logic e_busy, input logic e_taken,
                               input logic e_err, input string tag);
    exp_t e;
    exp_t got;
    pc_write      = pw;
    pc_write_cond = pwc;
    cond_sel      = cs;
    next_pc       = npc;
    zero          = z;
    gt            = g;
    flags_valid   = fv;
    except        = ex;
    e.pc       = e_pc;
    e.epc      = m_epc;
    e.busy     = e_busy;
    e.taken    = e_taken;
    e.cond_err = e_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checkOutput({tag, ".pc"},       pc,              got.pc);
    checkOutput({tag, ".epc"},      epc,             got.epc);
    checkOutput({tag, ".busy"},     {31'b0, busy},   {31'b0, got.busy});
    checkOutput({tag, ".taken"},    {31'b0, taken},  {31'b0, got.taken});
    checkOutput({tag, ".cond_err"}, {31'b0, cond_err}, {31'b0, got.cond_err});
  endtask

  task automatic idleCycle(input logic [31:0] e_pc, input logic e_busy,
                           input logic e_err, input string tag);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                  e_pc, e_busy, 1'b0, e_err, tag);
  endtask

  task automatic noteBranch(input bit t);
    if (t) m_taken++;
    else   m_ntaken++;
  endtask

  task automatic checkCounters(input string tag);
    int et;
    int en;
    et = STATS_ON ? ((m_taken  > CNT_SAT) ? CNT_SAT : m_taken)  : 0;
    en = STATS_ON ? ((m_ntaken > CNT_SAT) ? CNT_SAT : m_ntaken) : 0;
    checkOutput({tag, ".taken_cnt"},  {30'b0, taken_cnt},  et);
    checkOutput({tag, ".ntaken_cnt"}, {30'b0, ntaken_cnt}, en);
  endtask

  initial begin
    logic t;
    truth[0] = 3'b000;
    truth[1] = 3'b100;
    truth[2] = 3'b011;
    truth[3] = 3'b010;
    truth[4] = 3'b001;
    truth[5] = 3'b110;
    truth[6] = 3'b101;
    truth[7] = 3'b111;

    m_epc = 32'h0; m_taken = 0; m_ntaken = 0;
    pc_write = 0; pc_write_cond = 0; cond_sel = 0; next_pc = 0;
    zero = 0; gt = 0; flags_valid = 0; except = 0;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.pc",       pc,              32'h0);
    checkOutput("rst.epc",      epc,             32'h0);
    checkOutput("rst.busy",     {31'b0, busy},   32'h0);
    checkOutput("rst.taken",    {31'b0, taken},  32'h0);
    checkOutput("rst.cond_err", {31'b0, cond_err}, 32'h0);
    checkCounters("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Stats: five taken branches saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 3'd7, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b1, 1'b0,
                    32'h100 + 32'(i * 4), 1'b0, 1'b1, 1'b0, "stats");
      noteBranch(1'b1);
    end
    checkCounters("stats");

    // Full-width load, no truncation
    applyStimulus(1'b1, 1'b0, 3'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, "wide");

    // never/always resolve in IDLE without valid flags
    applyStimulus(1'b0, 1'b1, 3'd7, 32'h70, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h70, 1'b0, 1'b1, 1'b0, "always_nf");
    noteBranch(1'b1);
    applyStimulus(1'b0, 1'b1, 3'd0, 32'h74, 1'b1, 1'b0, 1'b0, 1'b0,
                  32'h70, 1'b0, 1'b0, 1'b0, "never_nf");
    noteBranch(1'b0);

    // Condition sweep
    for (int cs = 0; cs < 8; cs++) begin
      for (int p = 0; p < 3; p++) begin
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                      32'h0, 1'b0, 1'b0, 1'b0, "sweep_clr");
        t = truth[cs][p];
        applyStimulus(1'b0, 1'b1, 3'(cs), 32'h40, (p == 2), (p == 1), 1'b1, 1'b0,
                      t ? 32'h40 : 32'h0, 1'b0, t, 1'b0,
                      $sformatf("sweep_c%0d_p%0d", cs, p));
        noteBranch(t);
      end
    end
    checkCounters("sweep");

    // Late flags: EQ waits two cycles, then zero=1 resolves to taken
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h0, 1'b0, 1'b0, 1'b0, "late_clr");
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h0, 1'b1, 1'b0, 1'b0, "late_req");
    idleCycle(32'h0, 1'b1, 1'b0, "late_wait");
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0,
                  32'h80, 1'b0, 1'b1, 1'b0, "late_res");
    noteBranch(1'b1);

    // New pc_write_cond while waiting is ignored; latched target wins
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h80, 1'b1, 1'b0, 1'b0, "ign_req");
    applyStimulus(1'b0, 1'b1, 3'd7, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h80, 1'b1, 1'b0, 1'b0, "ign_new");
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0,
                  32'h50, 1'b0, 1'b1, 1'b0, "ign_res");
    noteBranch(1'b1);
    checkCounters("late");

    // Timeout: busy for TIMEOUT cycles, one cond_err, pc holds, no count
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h90, 1'b1, 1'b0, 1'b0, 1'b0,
                  32'h50, 1'b1, 1'b0, 1'b0, "tmo_req");
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0,
                    32'h50, 1'b1, 1'b0, 1'b0, "tmo_wait");
    end
    idleCycle(32'h50, 1'b0, 1'b1, "tmo_err");
    idleCycle(32'h50, 1'b0, 1'b0, "tmo_after");
    checkCounters("tmo");

    // Simultaneous except + pc_write + pc_write_cond: except wins
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h10, 1'b0, 1'b0, 1'b0, "sim_set");
    m_epc = 32'h10;
    applyStimulus(1'b1, 1'b1, 3'd7, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1,
                  EXC_VEC, 1'b0, 1'b0, 1'b0, "sim_exc");

    // Exception during WAIT drops the branch without cond_err
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h24, 1'b0, 1'b0, 1'b0, "wexc_set");
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h24, 1'b1, 1'b0, 1'b0, "wexc_req");
    m_epc = 32'h24;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1,
                  EXC_VEC, 1'b0, 1'b0, 1'b0, "wexc_exc");
    for (int i = 0; i < TIMEOUT + 1; i++) idleCycle(EXC_VEC, 1'b0, 1'b0, "wexc_after");

    // pc_write during WAIT overrides even with flags valid
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0,
                  EXC_VEC, 1'b1, 1'b0, 1'b0, "wpw_req");
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0,
                  32'h44, 1'b0, 1'b0, 1'b0, "wpw_load");
    for (int i = 0; i < TIMEOUT + 1; i++) idleCycle(32'h44, 1'b0, 1'b0, "wpw_after");
    checkCounters("drops");

    // Reset asserted mid-WAIT acts immediately
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h34, 1'b0, 1'b0, 1'b0, 1'b0,
                  32'h44, 1'b1, 1'b0, 1'b0, "mrst_req");
    pc_write_cond = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    m_epc = 32'h0; m_taken = 0; m_ntaken = 0;
    checkOutput("mrst.pc",   pc,            32'h0);
    checkOutput("mrst.epc",  epc,           32'h0);
    checkOutput("mrst.busy", {31'b0, busy}, 32'h0);
    checkCounters("mrst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycle(32'h0, 1'b0, 1'b0, "mrst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
